// File: rtl/unita_controllo_pkg.sv
// Shared encodings for the ARM-subset control unit.
package unita_controllo_pkg;

  // Instruction class, Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Data-processing cmd, Instr[24:21]
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // Condition codes, Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // ALUControl encoding
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // ImmSrc encoding
  localparam logic IMM_12 = 1'b0;  // 12-bit zero-extend
  localparam logic IMM_24 = 1'b1;  // 24-bit sign-extend, << 2

endpackage

// File: rtl/unita_controllo_cond_check.sv
// NZCV flag register and ARM condition-field evaluation.
module unita_controllo_cond_check
  import unita_controllo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,   // {N, Z, C, V} from the ALU
  input  logic       flag_write,  // decoder request, already qualified by legality
  output logic       CondEx
);

  logic [3:0] flags_q;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // Evaluate the condition against the registered flags (no forwarding)
  always_comb begin
    CondEx = 1'b0;
    case (cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;  // COND_NV never executes
    endcase
  end

  // Capture ALU flags only for executing flag-setting instructions
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flag_write && CondEx) begin
      flags_q <= alu_flags;
    end
  end

endmodule

// File: rtl/unita_controllo.sv
// Control unit for the single-cycle ARM-subset processor: decode, condition gating.
module unita_controllo
  import unita_controllo_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Z,
  input  logic        N,
  input  logic        C,
  input  logic        V,
  output logic        PCSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic        ImmSrc,
  output logic        ALUSrc,
  output logic        ALUControl,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        Illegal
);

  logic reg_write_dec, mem_write_dec, pc_src_dec, flag_write_dec;
  logic cond_ex, enable;

  // Rn and shift-amount/Rm fields are consumed by the datapath only
  logic unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[3:0]};

  // Decode the instruction class and command into raw control values
  always_comb begin
    reg_write_dec  = 1'b0;
    mem_write_dec  = 1'b0;
    pc_src_dec     = 1'b0;
    flag_write_dec = 1'b0;
    RegSrc         = 2'b00;
    ImmSrc         = IMM_12;
    ALUSrc         = 1'b0;
    ALUControl     = ALU_ADD;
    MemtoReg       = 1'b0;
    Illegal        = 1'b0;
    unique case (Instr[27:26])
      OP_DP: begin
        ALUSrc = Instr[25];
        // Only unshifted register operands are supported
        if (!Instr[25] && (Instr[11:4] != 8'h00)) Illegal = 1'b1;
        case (Instr[24:21])
          CMD_ADD: begin
            ALUControl     = ALU_ADD;
            reg_write_dec  = 1'b1;
            flag_write_dec = Instr[20];
          end
          CMD_SUB: begin
            ALUControl     = ALU_SUB;
            reg_write_dec  = 1'b1;
            flag_write_dec = Instr[20];
          end
          CMD_CMP: begin
            ALUControl     = ALU_SUB;
            flag_write_dec = 1'b1;
          end
          default: Illegal = 1'b1;
        endcase
        pc_src_dec = reg_write_dec && (Instr[15:12] == 4'hF);
      end
      OP_MEM: begin
        // Immediate offset, pre-indexed, word, no writeback
        if (Instr[25] || !Instr[24] || Instr[22] || Instr[21]) Illegal = 1'b1;
        ALUSrc     = 1'b1;
        ALUControl = ~Instr[23];
        if (Instr[20]) begin
          MemtoReg      = 1'b1;
          reg_write_dec = 1'b1;
          pc_src_dec    = (Instr[15:12] == 4'hF);
        end else begin
          mem_write_dec = 1'b1;
          RegSrc[1]     = 1'b1;
        end
      end
      OP_BR: begin
        if (Instr[24]) Illegal = 1'b1;  // BL unsupported
        RegSrc[0]  = 1'b1;
        ALUSrc     = 1'b1;
        ImmSrc     = IMM_24;
        ALUControl = ALU_ADD;
        pc_src_dec = 1'b1;
      end
      default: Illegal = 1'b1;
    endcase
  end

  unita_controllo_cond_check u_cond_check (
    .clock      (clock),
    .reset      (reset),
    .cond       (Instr[31:28]),
    .alu_flags  ({N, Z, C, V}),
    .flag_write (flag_write_dec & ~Illegal),
    .CondEx     (cond_ex)
  );

  // Architectural side effects only for legal, executing instructions outside reset
  always_comb begin
    enable   = cond_ex & ~Illegal & ~reset;
    RegWrite = reg_write_dec & enable;
    MemWrite = mem_write_dec & enable;
    PCSrc    = pc_src_dec & enable;
  end

endmodule

// File: tb/tb_unita_controllo.sv
// Directed, table-driven bench for unita_controllo.
module tb_unita_controllo;

  logic        clock, reset;
  logic [31:0] Instr;
  logic        Z, N, C, V;
  logic        PCSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, Illegal;
  logic [1:0]  RegSrc;
  logic [9:0]  outv;

  int total = 0;
  int bad   = 0;

  unita_controllo dut (
    .clock      (clock),
    .reset      (reset),
    .Instr      (Instr),
    .Z          (Z),
    .N          (N),
    .C          (C),
    .V          (V),
    .PCSrc      (PCSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .Illegal    (Illegal)
  );

  // {PCSrc, RegSrc[1:0], RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, Illegal}
  assign outv = {PCSrc, RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg,
                 Illegal};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  nzcv;
    logic [9:0]  exp;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl [NVEC];

  task automatic drive(input logic [31:0] ins, input logic [3:0] nzcv, input logic rst);
    Instr        = ins;
    {N, Z, C, V} = nzcv;
    reset        = rst;
  endtask

  task automatic chk(input string name, input logic [9:0] exp);
    total++;
    if (outv !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, outv, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  initial begin
    // Flags evolve down the table; each row is one clock cycle
    tbl[0]  = {32'hE2821005, 4'b0000, 10'b0_00_1_0_1_0_0_0_0};  // ADD R1,R2,#5
    tbl[1]  = {32'hE3510005, 4'b0100, 10'b0_00_0_0_1_1_0_0_0};  // CMP, Z=1 captured
    tbl[2]  = {32'h0A000002, 4'b0000, 10'b1_01_0_1_1_0_0_0_0};  // BEQ taken
    tbl[3]  = {32'hE5843008, 4'b0000, 10'b0_10_0_0_1_0_1_0_0};  // STR U=1
    tbl[4]  = {32'hE5043008, 4'b0000, 10'b0_10_0_0_1_1_1_0_0};  // STR U=0
    tbl[5]  = {32'hE5965004, 4'b0000, 10'b0_00_1_0_1_0_0_1_0};  // LDR
    tbl[6]  = {32'h15965004, 4'b0000, 10'b0_00_0_0_1_0_0_1_0};  // LDRNE, Z=1 fails
    tbl[7]  = {32'hEE000000, 4'b1111, 10'b0_00_0_0_0_0_0_0_1};  // op 11
    tbl[8]  = {32'hE0821103, 4'b1111, 10'b0_00_0_0_0_0_0_0_1};  // shifted register
    tbl[9]  = {32'h0A000002, 4'b0000, 10'b1_01_0_1_1_0_0_0_0};  // BEQ: Z still 1
    tbl[10] = {32'h1A000002, 4'b0000, 10'b0_01_0_1_1_0_0_0_0};  // BNE fails
    tbl[11] = {32'hE2521001, 4'b1000, 10'b0_00_1_0_1_1_0_0_0};  // SUBS, NZCV=1000
    tbl[12] = {32'h4A000002, 4'b0000, 10'b1_01_0_1_1_0_0_0_0};  // BMI taken
    tbl[13] = {32'h5A000002, 4'b0000, 10'b0_01_0_1_1_0_0_0_0};  // BPL fails
    tbl[14] = {32'hE282F005, 4'b0000, 10'b1_00_1_0_1_0_0_0_0};  // ADD R15: PCSrc
    tbl[15] = {32'h02921005, 4'b0100, 10'b0_00_0_0_1_0_0_0_0};  // ADDSEQ fails, no capture
    tbl[16] = {32'h0A000002, 4'b0000, 10'b0_01_0_1_1_0_0_0_0};  // BEQ fails
    tbl[17] = {32'hF2821005, 4'b0000, 10'b0_00_0_0_1_0_0_0_0};  // cond 1111 never
    tbl[18] = {32'hBA000002, 4'b0000, 10'b1_01_0_1_1_0_0_0_0};  // BLT, N!=V
    tbl[19] = {32'hAA000002, 4'b0000, 10'b0_01_0_1_1_0_0_0_0};  // BGE fails
    tbl[20] = {32'hE3510005, 4'b0010, 10'b0_00_0_0_1_1_0_0_0};  // CMP, NZCV=0010
    tbl[21] = {32'h8A000002, 4'b0000, 10'b1_01_0_1_1_0_0_0_0};  // BHI taken
    tbl[22] = {32'h9A000002, 4'b0000, 10'b0_01_0_1_1_0_0_0_0};  // BLS fails
    tbl[23] = {32'hE2421001, 4'b1111, 10'b0_00_1_0_1_1_0_0_0};  // SUB S=0, no capture
    tbl[24] = {32'h8A000002, 4'b0000, 10'b1_01_0_1_1_0_0_0_0};  // BHI still taken
    tbl[25] = {32'hE0921103, 4'b0100, 10'b0_00_0_0_0_0_0_0_1};  // illegal ADDS, no capture
    tbl[26] = {32'h8A000002, 4'b0000, 10'b1_01_0_1_1_0_0_0_0};  // BHI still taken

    // Reset state: BNE would pass on NZCV=0000 but reset gates PCSrc
    drive(32'h1A000002, 4'b0000, 1'b1);
    @(negedge clock);
    chk("reset_gate_bne", 10'b0_01_0_1_1_0_0_0_0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_flags_zero_bne", 10'b1_01_0_1_1_0_0_0_0);

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clock); #1;
      drive(tbl[i].instr, tbl[i].nzcv, 1'b0);
      @(negedge clock);
      total++;
      if (outv !== tbl[i].exp) begin
        bad++;
        $display("FAIL vec%0d instr=%h: got %b expected %b", i, tbl[i].instr, outv,
                 tbl[i].exp);
      end
    end

    // Asynchronous reset clears flags immediately, mid-cycle
    @(posedge clock); #1;
    drive(32'hE3510005, 4'b0100, 1'b0);
    @(negedge clock);
    chk("cmp_set_z", 10'b0_00_0_0_1_1_0_0_0);
    @(posedge clock); #1;
    drive(32'h0A000002, 4'b0000, 1'b0);
    #2;
    chk1("beq_before_async_reset", PCSrc, 1'b1);
    reset = 1'b1;
    #1;
    chk1("beq_during_async_reset", PCSrc, 1'b0);
    reset = 1'b0;
    #1;
    chk1("beq_after_async_reset", PCSrc, 1'b0);

    // Reset held across an edge: pending CMP result discarded, writes gated
    @(posedge clock); #1;
    drive(32'hE3510005, 4'b0100, 1'b1);
    @(negedge clock);
    chk("cmp_in_reset", 10'b0_00_0_0_1_1_0_0_0);
    @(posedge clock); #1;
    drive(32'hE2821005, 4'b0000, 1'b1);
    @(negedge clock);
    chk("add_in_reset", 10'b0_00_0_0_1_0_0_0_0);
    @(posedge clock); #1;
    drive(32'hE5843008, 4'b0000, 1'b1);
    @(negedge clock);
    chk("str_in_reset", 10'b0_10_0_0_1_0_0_0_0);
    @(posedge clock); #1;
    drive(32'h0A000002, 4'b0000, 1'b0);
    @(negedge clock);
    chk("beq_after_reset", 10'b0_01_0_1_1_0_0_0_0);
    @(posedge clock); #1;
    drive(32'h1A000002, 4'b0000, 1'b0);
    @(negedge clock);
    chk("bne_after_reset", 10'b1_01_0_1_1_0_0_0_0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unita_controllo.md
# unita_controllo

Control unit for the single-cycle ARM-subset processor. It decodes the fetched 32-bit instruction, evaluates the ARM condition field against an internal NZCV flag register, and drives every control input of the datapath. The datapath's ALU flags are captured back into this block. The block sits between the instruction memory output and the datapath control pins, closing the loop the datapath leaves open.

## Interface
- No parameters.
- clock  in  1  rising-edge clock, shared with the datapath
- reset  in  1  asynchronous, active-high
- Instr  in  32  current instruction from instruction memory
- Z, N, C, V  in  1 each  flags from the main ALU for the current instruction
- PCSrc  out  1  1: next PC = Result
- RegSrc  out  2  [0]: RA1 = R15; [1]: RA2 = Instr[15:12]
- RegWrite  out  1  register file write enable
- ImmSrc  out  1  0: 12-bit zero-extend; 1: 24-bit sign-extend, shifted left 2
- ALUSrc  out  1  1: SrcB = ExtImm
- ALUControl  out  1  0: add; 1: subtract
- MemWrite  out  1  data memory write enable
- MemtoReg  out  1  1: Result = ReadData
- Illegal  out  1  current instruction is unsupported

## Operation
- Supported classes, selected by Instr[27:26]:
  - 00 data processing: ADD (0100), SUB (0010), CMP (1010).
  - 01 memory: LDR/STR, immediate offset, P=1, B=0, W=0.
  - 10 branch: B, with L=0.
- Anything else asserts Illegal. This includes a register operand with Instr[11:4]≠0, op 11, BL, byte or writeback accesses, and other cmd values.
- Decode:
  - ADD/SUB: ALUSrc=I; ImmSrc=0; ALUControl = 0 for ADD, 1 for SUB; RegWrite=1.
  - CMP: ALUControl=1; RegWrite=0; flags are always updated.
  - LDR/STR: ALUSrc=1; ImmSrc=0; ALUControl = ~U.
    - LDR: MemtoReg=1, RegWrite=1.
    - STR: MemWrite=1, RegSrc[1]=1.
  - B: RegSrc[0]=1; ALUSrc=1; ImmSrc=1; ALUControl=0; PCSrc=1.
- Condition check uses the registered flags. Supported codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL. Code 1111 never passes.
- Gating: RegWrite, MemWrite and PCSrc are forced to 0 whenever any of these hold: the condition fails, Illegal=1, or reset=1.
- A passing DP or LDR instruction with Rd=15 also asserts PCSrc (and RegWrite stays 1).
- Flag register:
  - Reset value: NZCV=0000.
  - Captures {N,Z,C,V} at the rising clock edge when the condition passes, the instruction is not illegal, and the instruction is either CMP or ADD/SUB with S=1.
- Don't-care outputs (for example MemtoReg on a branch) are driven 0.

## Timing
- Decode and condition evaluation are combinational from Instr and the registered flags, valid in the same cycle. Latency is 0 cycles.
- A flag update made by instruction k is visible to instruction k+1. There is no same-cycle forwarding.
- Reset:
  - Asserted: clears the flags immediately and gates all write enables and PCSrc.
  - Deasserted: normal decode resumes on the next instruction.
- Reset asserted mid-program: pending flag results are discarded, and a following conditional instruction sees NZCV=0000.
- Outputs while reset=1: PCSrc=0, RegWrite=0, MemWrite=0. The other outputs follow decode.

## Structure
- Shared package contents:
  - op-class constants (DP=00, MEM=01, BR=10);
  - cmd constants (ADD, SUB, CMP);
  - cond-code constants;
  - ALUControl encoding (ALU_ADD=0, ALU_SUB=1);
  - ImmSrc encoding.
- One sub-module, cond_check, holds the NZCV register and the condition evaluation.
  - Inputs: clock, reset, cond, ALU flags, flag-write request.
  - Output: CondEx.
- The decoder body stays in unita_controllo.

## Test plan
- ADD R1,R2,#5 (E2821005), flags 0000 → RegWrite=1, ALUSrc=1, ImmSrc=0, ALUControl=0, RegSrc=00, MemWrite=0, MemtoReg=0, PCSrc=0, Illegal=0.
- CMP R1,#5 (E3510005) with input Z=1, then BEQ (0A000002) → CMP: RegWrite=0, ALUControl=1. Next cycle BEQ: PCSrc=1, RegSrc[0]=1, ImmSrc=1, ALUSrc=1, RegWrite=0.
- STR R3,[R4,#8] (E5843008) → MemWrite=1, RegSrc=10, ALUControl=0, RegWrite=0. The same instruction with U=0 (E5043008) gives ALUControl=1.
- LDR R5,[R6,#4] (E5965004) → MemtoReg=1, RegWrite=1, ALUSrc=1. The same instruction with cond=NE (15965004) and registered Z=1 gives RegWrite=0.
- Reset pulse after CMP has set Z=1 → BEQ (0A000002) yields PCSrc=0. While reset=1, RegWrite=MemWrite=PCSrc=0 for ADD (E2821005).
- EE000000 (op 11) and ADD with a shifted register (E0821103) → Illegal=1, and RegWrite=MemWrite=PCSrc=0. Flags are unchanged on the next cycle.
